// File: rtl/bit8_mem.sv
// bit8_mem: 8-entry x 32-bit synchronous lookup store.
// Reset loads mem[i] = (i+1)*100. It has one registered read port and one write port,
// and both use the same address.
// A read on the same edge as a write to the same address returns the old word.
//
// Ports:
//   clk      in  1           clock, all state changes on rising edge
//   rst      in  1           synchronous active-high reset
//   address  in  ADDR_WIDTH  read/write word address
//   readE    in  1           read enable
//   writeE   in  1           write enable
//   wdata    in  DATA_WIDTH  write data
//   data     out DATA_WIDTH  registered read data, holds between reads
//   valid    out 1           high for the cycle after an accepted read
module bit8_mem #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  readE,
  input  logic                  writeE,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] mem_d [Depth];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  // The read uses mem_q, which is the pre-write contents. This gives read-before-write.
  always_comb begin
    mem_d   = mem_q;
    data_d  = data_q;
    valid_d = readE;
    if (readE) begin
      data_d = mem_q[address];
    end
    if (writeE) begin
      mem_d[address] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= DATA_WIDTH'((i + 1) * 100);
      end
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_bit8_mem.sv
// tb_bit8_mem is a scoreboard bench for bit8_mem.
// The driver applies one input set per cycle and pushes the expected outputs for that edge.
// It takes the expected outputs from a behavioural model.
// The monitor pops one entry after each edge and compares it with the DUT outputs.
module tb_bit8_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  address;
  logic        readE;
  logic        writeE;
  logic [31:0] wdata;
  logic [31:0] data;
  logic        valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural reference state
  logic [31:0] ref_mem [8];
  logic [31:0] ref_data;

  bit8_mem #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .address(address),
    .readE  (readE),
    .writeE (writeE),
    .wdata  (wdata),
    .data   (data),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  // Drive inputs just after the falling edge, so they are stable at the next rising edge.
  // Push what the outputs must be after that rising edge.
  task automatic step(input logic r, input logic re, input logic we, input int a,
                      input logic [31:0] wd);
    exp_t e;
    int   idx;
    @(negedge clk);
    #1;
    rst     = r;
    readE   = re;
    writeE  = we;
    address = 3'(a);
    wdata   = wd;
    idx     = a % 8;
    if (r) begin
      for (int i = 0; i < 8; i++) ref_mem[i] = (i + 1) * 100;
      ref_data = 32'd0;
      e.v      = 1'b0;
    end else begin
      e.v = re;
      if (re) ref_data = ref_mem[idx];
      if (we) ref_mem[idx] = wd;
    end
    e.d = ref_data;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.v) begin
          errors++;
          $display("FAIL valid: got %b expected %b at %0t", valid, e.v, $time);
        end
        checks++;
        if (data !== e.d) begin
          errors++;
          $display("FAIL data: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                   data, data, e.d, e.d, $time);
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; readE = 1'b0; writeE = 1'b0; address = '0; wdata = '0;

    // Reset, then a sequential read sweep of all eight entries.
    step(1, 0, 0, 0, 0);
    for (int a = 0; a < 8; a++) step(0, 1, 0, a, 0);

    // Pulsed reads over 0..15. The address wraps mod 8, and data holds between pulses.
    for (int a = 0; a < 16; a++) begin
      step(0, 1, 0, a, 0);
      step(0, 0, 0, a, 0);
    end

    // Write, then read it back. The neighbouring entry is untouched.
    step(0, 0, 1, 3, 32'hDEADBEEF);
    step(0, 1, 0, 3, 0);
    step(0, 1, 0, 4, 0);

    // Same-edge read and write to one address returns the old word.
    step(0, 1, 1, 5, 32'd7);
    step(0, 1, 0, 5, 0);

    // Reset in the middle of a read discards the read and restores the defaults.
    step(0, 0, 1, 0, 32'd1);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // Long idle after a read.
    step(0, 1, 0, 7, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 7, 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 15)), $urandom);
    end
    step(0, 0, 0, 0, 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
